// File: rtl/dwt_lift_step.sv
// One lifting step pair of the 9/7 row DWT: predict d[k] with CoefA, then update s[k] with CoefB,
// with symmetric line-edge extension, round-half-up, optional saturation and line-protocol checks.
module dwt_lift_step #(
    parameter int  DataWidth = 16,
    parameter int  Point     = 10,
    parameter real CoefA     = -0.5,
    parameter real CoefB     = 0.25,
    parameter bit  Saturate  = 1'b1,
    parameter int  MaxPairs  = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     s_ready_o,
    input  logic                     s_valid_i,
    input  logic                     s_sof_i,
    input  logic                     s_eol_i,
    input  logic [2*DataWidth-1:0]   s_data_i,
    input  logic                     m_ready_i,
    output logic                     m_valid_o,
    output logic                     m_sof_o,
    output logic                     m_eol_o,
    output logic [2*DataWidth-1:0]   m_data_o,
    output logic                     err_o
);

    localparam int SW   = DataWidth + 1;
    localparam int CW   = 32;
    localparam int PW   = SW + CW;
    localparam int CNTW = $clog2(MaxPairs + 1);

    // Coefficients rounded to nearest, ties away from zero.
    localparam int IntA = (CoefA >= 0.0) ? $rtoi(CoefA * (2.0 ** Point) + 0.5)
                                         : -$rtoi(-CoefA * (2.0 ** Point) + 0.5);
    localparam int IntB = (CoefB >= 0.0) ? $rtoi(CoefB * (2.0 ** Point) + 0.5)
                                         : -$rtoi(-CoefB * (2.0 ** Point) + 0.5);

    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (Point - 1);
    localparam logic signed [PW:0]   MAXV = {{(PW-DataWidth+2){1'b0}}, {(DataWidth-1){1'b1}}};
    localparam logic signed [PW:0]   MINV = {{(PW-DataWidth+2){1'b1}}, {(DataWidth-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    state_t state_q, state_d;

    logic signed [DataWidth-1:0] xe_q, xo_q, dprev_q;
    logic                        first_q;
    logic [CNTW-1:0]             cnt_q, cnt_d;

    logic                        out_free, acc;
    logic                        take, new_line, load_out, err_d, at_max;
    logic signed [DataWidth-1:0] in_odd, in_even, xn, d_cur, dm1, s_cur;

    function automatic logic signed [PW-1:0] scale(input logic signed [SW-1:0] sum,
                                                   input logic signed [CW-1:0] coef);
        logic signed [PW-1:0] p;
        p = PW'(sum) * PW'(coef);
        return (p + HALF) >>> Point;
    endfunction

    function automatic logic signed [DataWidth-1:0] fit(input logic signed [PW:0] v);
        if (Saturate && (v > MAXV))
            return MAXV[DataWidth-1:0];
        else if (Saturate && (v < MINV))
            return MINV[DataWidth-1:0];
        else
            return v[DataWidth-1:0];
    endfunction

    // base + round(coef * (a + b)), with the final add done wide before fitting.
    function automatic logic signed [DataWidth-1:0] lift(input logic signed [DataWidth-1:0] base,
                                                         input logic signed [DataWidth-1:0] a,
                                                         input logic signed [DataWidth-1:0] b,
                                                         input logic signed [CW-1:0]        coef);
        logic signed [SW-1:0] sum;
        logic signed [PW:0]   t;
        sum = SW'(a) + SW'(b);
        t   = (PW+1)'(base) + (PW+1)'(scale(sum, coef));
        return fit(t);
    endfunction

    assign in_odd   = s_data_i[2*DataWidth-1:DataWidth];
    assign in_even  = s_data_i[DataWidth-1:0];
    assign out_free = !m_valid_o || m_ready_i;
    assign s_ready_o = !rst_i && (state_q != FLUSH) && out_free;
    assign acc      = s_valid_i && s_ready_o;

    // The right neighbour of the pending even sample is the incoming even, or itself at line end.
    assign xn    = (state_q == FLUSH) ? xe_q : in_even;
    assign d_cur = lift(xo_q, xe_q, xn, IntA);
    assign dm1   = first_q ? d_cur : dprev_q;
    assign s_cur = lift(xe_q, dm1, d_cur, IntB);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        take     = 1'b0;
        new_line = 1'b0;
        load_out = 1'b0;
        err_d    = 1'b0;
        at_max   = 1'b0;
        case (state_q)
            IDLE, PEND: begin
                if (acc) begin
                    if (s_sof_i) begin
                        // A sof while a pair is pending abandons that pair without output.
                        new_line = 1'b1;
                        take     = 1'b1;
                        cnt_d    = CNTW'(1);
                        err_d    = (state_q == PEND);
                    end else if (state_q == PEND) begin
                        take     = 1'b1;
                        load_out = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end else begin
                        err_d    = 1'b1;
                    end
                    if (take) begin
                        at_max  = (cnt_d == CNTW'(MaxPairs));
                        if (at_max && !s_eol_i)
                            err_d = 1'b1;
                        state_d = (s_eol_i || at_max) ? FLUSH : PEND;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load_out = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xe_q      <= '0;
            xo_q      <= '0;
            dprev_q   <= '0;
            first_q   <= 1'b0;
            cnt_q     <= '0;
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eol_o   <= 1'b0;
            m_data_o  <= '0;
            err_o     <= 1'b0;
        end else begin
            err_o <= err_d;
            cnt_q <= cnt_d;
            if (take) begin
                xe_q <= in_even;
                xo_q <= in_odd;
            end
            if (load_out)
                dprev_q <= d_cur;
            if (new_line)
                first_q <= 1'b1;
            else if (load_out)
                first_q <= 1'b0;
            if (load_out) begin
                m_valid_o <= 1'b1;
                m_data_o  <= {d_cur, s_cur};
                m_sof_o   <= first_q;
                m_eol_o   <= (state_q == FLUSH);
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dwt_lift_step.sv
// Bench for dwt_lift_step: directed steps plus random lines checked against an arithmetic
// model of the lifting equations; a second instance runs with Saturate=0.
module tb_dwt_lift_step;

    localparam longint IA = -512;   // -0.5 in Q10
    localparam longint IB = 256;    //  0.25 in Q10

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_sof, s_eol, m_ready;
    logic [31:0] s_data;
    logic        s_ready, m_valid, m_sof, m_eol, err;
    logic [31:0] m_data;
    logic        w_s_ready, w_m_valid, w_m_sof, w_m_eol, w_err;
    logic [31:0] w_m_data;

    always #5 clk = ~clk;

    dwt_lift_step #(.Saturate(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .s_ready_o(s_ready), .s_valid_i(s_valid),
        .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready),
        .m_valid_o(m_valid), .m_sof_o(m_sof), .m_eol_o(m_eol), .m_data_o(m_data), .err_o(err)
    );

    dwt_lift_step #(.Saturate(1'b0)) dut_w (
        .clk_i(clk), .rst_i(rst), .s_ready_o(w_s_ready), .s_valid_i(s_valid),
        .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready),
        .m_valid_o(w_m_valid), .m_sof_o(w_m_sof), .m_eol_o(w_m_eol), .m_data_o(w_m_data), .err_o(w_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int errc = 0;
    int rdy_lo = 0;
    int xo_l[0:299];
    int xe_l[0:299];
    logic [33:0] got_q[$];
    logic [33:0] got_w[$];
    logic [33:0] exp_q[$];

    // Record every output transfer as {sof, eol, d, s}.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (m_valid && m_ready)   got_q.push_back({m_sof, m_eol, m_data});
            if (w_m_valid && m_ready) got_w.push_back({w_m_sof, w_m_eol, w_m_data});
            if (err)      errc   <= errc + 1;
            if (!s_ready) rdy_lo <= rdy_lo + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic int fitv(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic longint rnd(input longint c, input longint v);
        return (c * v + 512) >>> 10;
    endfunction

    // Expected outputs of an n-pair line starting at xo_l/xe_l[base], straight from the equations.
    task automatic model(input int base, input int n);
        int x[];
        int d[];
        int dm, s;
        x = new[2*n+1];
        d = new[n];
        for (int i = 0; i < n; i++) begin
            x[2*i]   = xe_l[base+i];
            x[2*i+1] = xo_l[base+i];
        end
        x[2*n] = x[2*n-2];
        for (int k = 0; k < n; k++)
            d[k] = fitv(longint'(x[2*k+1]) + rnd(IA, longint'(x[2*k] + x[2*k+2])));
        for (int k = 0; k < n; k++) begin
            dm = (k == 0) ? d[0] : d[k-1];
            s  = fitv(longint'(x[2*k]) + rnd(IB, longint'(dm + d[k])));
            exp_q.push_back({(k == 0), (k == n-1), 16'(d[k]), 16'(s)});
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            xo_l[i] = int'($urandom_range(0, 65535)) - 32768;
            xe_l[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    // Called at a negedge; returns at the negedge after the pair is accepted.
    task automatic send(input logic [15:0] odd, input logic [15:0] even, input bit sof, input bit eol);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_sof   = sof;
        s_eol   = eol;
        s_data  = {odd, even};
        #1;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $error("FAIL send_timeout: s_ready observed 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic send_line(input int base, input int n, input bit eol_last, input int lo, input int hi);
        for (int i = lo; i < hi; i++)
            send(16'(xo_l[base+i]), 16'(xe_l[base+i]), (i == 0), (i == n-1) && eol_last);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
        got_w.delete();
    endtask

    initial begin
        int r0, e0, c0, n0;
        logic [34:0] hold;

        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_sof",   64'(m_sof),   64'(0));
        chk("rst_eol",   64'(m_eol),   64'(0));
        chk("rst_data",  64'(m_data),  64'(0));
        chk("rst_err",   64'(err),     64'(0));
        chk("rst_ready", 64'(s_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(s_ready), 64'(1));

        // Nominal two-pair line with hand-derived results.
        send(16'd2048, 16'd1024, 1'b1, 1'b0);
        send(16'd4096, 16'd3072, 1'b0, 1'b1);
        chk("nominal_latency", 64'({m_valid, m_data}), 64'({1'b1, 16'd0, 16'd1024}));
        exp_q.push_back({1'b1, 1'b0, 16'd0,    16'd1024});
        exp_q.push_back({1'b0, 1'b1, 16'd1024, 16'd3328});
        drain("nominal");

        // Single-pair line: input stalls for the FLUSH beat only.
        r0 = rdy_lo;
        send(16'd1024, 16'd1024, 1'b1, 1'b1);
        exp_q.push_back({1'b1, 1'b1, 16'd0, 16'd1024});
        drain("single");
        chk("single_ready_low", 64'(rdy_lo - r0), 64'(1));

        // Saturation vs wrap on the first d.
        send(16'h7FFF, 16'h8000, 1'b1, 1'b0);
        send(16'h0000, 16'h8000, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("sat_count",  64'(got_q.size()), 64'(2));
        chk("wrap_count", 64'(got_w.size()), 64'(2));
        if (got_q.size() > 0) chk("sat_hi",  64'(got_q[0][31:16]), 64'(16'h7FFF));
        if (got_w.size() > 0) chk("wrap_hi", 64'(got_w[0][31:16]), 64'(16'hFFFF));
        xo_l[0] = 32767; xe_l[0] = -32768; xo_l[1] = 0; xe_l[1] = -32768;
        model(0, 2);
        drain("sat_line");

        // Random 8-pair line with a 5-cycle output stall in the middle.
        fill(8);
        send_line(0, 8, 1'b1, 0, 4);
        m_ready = 1'b0;
        hold = {m_valid, m_sof, m_eol, m_data};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold",  64'({m_valid, m_sof, m_eol, m_data}), 64'(hold));
            chk("stall_ready", 64'(s_ready), 64'(0));
        end
        chk("stall_valid", 64'(hold[34]), 64'(1));
        m_ready = 1'b1;
        send_line(0, 8, 1'b1, 4, 8);
        model(0, 8);
        drain("backpressure");

        // Two back-to-back lines: one pair per cycle plus one FLUSH cycle per line.
        fill(12);
        c0 = cyc;
        r0 = rdy_lo;
        send_line(0, 6, 1'b1, 0, 6);
        send_line(6, 6, 1'b1, 0, 6);
        chk("tput_cycles", 64'(cyc - c0), 64'(13));
        model(0, 6);
        model(6, 6);
        drain("tput");
        chk("tput_ready_low", 64'(rdy_lo - r0), 64'(2));

        // Protocol errors: pair without sof in IDLE, then sof while a pair is pending.
        fill(3);
        e0 = errc;
        send(16'(xo_l[0]), 16'(xe_l[0]), 1'b0, 1'b0);
        send(16'(xo_l[0]), 16'(xe_l[0]), 1'b1, 1'b0);
        send_line(1, 2, 1'b1, 0, 2);
        model(1, 2);
        drain("sof_err");
        chk("err_pulses", 64'(errc - e0), 64'(2));

        // Line of MaxPairs with no eol is closed by the block itself.
        fill(256);
        e0 = errc;
        send_line(0, 256, 1'b0, 0, 256);
        model(0, 256);
        drain("maxpairs");
        chk("maxpairs_err", 64'(errc - e0), 64'(1));

        // Reset in the middle of a line, then a clean line.
        fill(3);
        send_line(0, 3, 1'b0, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 64'(m_valid), 64'(0));
        chk("rst_mid_data",  64'(m_data),  64'(0));
        n0 = got_q.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rst_no_stale",   64'(got_q.size()), 64'(n0));
        chk("rst_idle_valid", 64'(m_valid), 64'(0));
        got_q.delete();
        got_w.delete();
        fill(3);
        send_line(0, 3, 1'b1, 0, 3);
        model(0, 3);
        drain("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
